hazard_track: RTL and testbench

Destination-register tracker and stall generator for the five-stage pipeline. Registers the decode-stage operand and destination fields down the X, M and W stages. Supplies the `Drs/Drt/Xrd/Xrt/Mrd` fields that the hazard unit compares for forwarding. Applies the resulting stall and bubble control back to the pipeline, inserting a one-cycle bubble on a load-use dependency.

---
 rtl/hazard_track_if.sv | 42 ++++
 rtl/hazard_track.sv | 89 ++++++++
 tb/tb_hazard_track.sv | 127 ++++++++++++
 3 files changed

// File: rtl/hazard_track_if.sv
// hazard_track_if: pipeline-side bundle for the hazard tracker.
//   master : the pipeline/decoder side. It drives the decode fields, flush
//            and ext_stall, and receives the tracked fields and stall controls.
//   slave  : the hazard_track block itself.
// Signals:
//   id_valid, id_rs/id_rt/id_rd, id_regwr, id_memrd : decode-stage instruction
//   flush, ext_stall                                : redirect kill / global hold
//   Drs, Drt, Xrd, Xrt, Mrd, Wrd                    : forwarding compare fields
//   stall_if, stall_d, bubble_x, bubble_cnt         : stall and bubble controls
interface hazard_track_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] id_rd;
    logic             id_regwr;
    logic             id_memrd;
    logic             flush;
    logic             ext_stall;
    logic [REG_W-1:0] Drs;
    logic [REG_W-1:0] Drt;
    logic [REG_W-1:0] Xrd;
    logic [REG_W-1:0] Xrt;
    logic [REG_W-1:0] Mrd;
    logic [REG_W-1:0] Wrd;
    logic             stall_if;
    logic             stall_d;
    logic             bubble_x;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_regwr, id_memrd, flush, ext_stall,
        input  Drs, Drt, Xrd, Xrt, Mrd, Wrd, stall_if, stall_d, bubble_x, bubble_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_regwr, id_memrd, flush, ext_stall,
        output Drs, Drt, Xrd, Xrt, Mrd, Wrd, stall_if, stall_d, bubble_x, bubble_cnt
    );
endinterface

// File: rtl/hazard_track.sv
// hazard_track: destination-register tracker and load-use stall generator
// for the five-stage pipeline.
//
// The block carries the decode destination down the X, M and W stages and
// exposes the fields that the forwarding comparators use. When a load in X
// feeds the instruction in decode, it holds fetch/decode for one cycle and
// puts a bubble into X.
//
// Ports:
//   clk   : pipeline clock
//   reset : asynchronous, active-high; clears X, M, W and the bubble counter
//   hif   : hazard_track_if.slave (decode inputs, flush, ext_stall, tracked
//           fields, stall_if/stall_d, bubble_x, bubble_cnt)
//
// Build option:
//   LOAD_USE_STALL_EN : when defined, load-use detection is active. When it is
//                       undefined, lu is tied to 0 and the memory-side forward
//                       covers load-use instead, so bubble_cnt stays 0.
module hazard_track #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           reset,
    hazard_track_if.slave  hif
);
    typedef struct packed {
        logic [REG_W-1:0] dst;
        logic [REG_W-1:0] rt;
        logic             memrd;
    } xstage_t;

    xstage_t          x_q, x_d;
    logic [REG_W-1:0] m_q, w_q;
    logic [CNT_W-1:0] cnt_q;
    logic [REG_W-1:0] drs, drt, ddst;
    logic             lu;

    // Index 0 means "no register". A missing or non-writing instruction
    // therefore shows up as 0 on its fields.
    assign drs  = hif.id_valid ? hif.id_rs : '0;
    assign drt  = hif.id_valid ? hif.id_rt : '0;
    assign ddst = (hif.id_valid && hif.id_regwr) ? hif.id_rd : '0;

`ifdef LOAD_USE_STALL_EN
    assign lu = x_q.memrd && (x_q.dst != '0) && ((x_q.dst == drs) || (x_q.dst == drt));
`else
    assign lu = 1'b0;
`endif

    // A flush or a load-use hazard both put an empty slot into X. A flush
    // overrides lu: the dependent instruction is discarded, so it is not held.
    always_comb begin
        x_d = '0;
        if (!hif.flush && !lu) begin
            x_d.dst   = ddst;
            x_d.rt    = drt;
            x_d.memrd = hif.id_valid && hif.id_memrd;
        end
    end

    // ext_stall freezes every stage and the counter. When lu coincides with
    // ext_stall, the bubble is counted on the first cycle the hold releases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            cnt_q <= '0;
        end else if (!hif.ext_stall) begin
            x_q <= x_d;
            m_q <= x_q.dst;
            w_q <= m_q;
            if (lu && !hif.flush && (cnt_q != '1))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign hif.Drs        = drs;
    assign hif.Drt        = drt;
    assign hif.Xrd        = x_q.dst;
    assign hif.Xrt        = x_q.rt;
    assign hif.Mrd        = m_q;
    assign hif.Wrd        = w_q;
    assign hif.stall_d    = (lu && !hif.flush) || hif.ext_stall;
    assign hif.stall_if   = (lu && !hif.flush) || hif.ext_stall;
    assign hif.bubble_x   = (x_q.dst == '0) && (x_q.rt == '0) && !x_q.memrd;
    assign hif.bubble_cnt = cnt_q;
endmodule

// File: tb/tb_hazard_track.sv
// Directed scoreboard bench for hazard_track. Each step drives one decode
// cycle shortly after the rising edge and queues that cycle's hand-computed
// outputs. A monitor pops the queue on the falling edge and compares.
// L selects the expected values for builds with or without LOAD_USE_STALL_EN.
module tb_hazard_track;
`ifdef LOAD_USE_STALL_EN
    localparam int L = 1;
`else
    localparam int L = 0;
`endif

    // inputs : valid rs rt rd regwr memrd flush ext_stall reset
    // expects: Drs Drt Xrd Xrt Mrd Wrd stall bubble_x bubble_cnt
    typedef int vin_t[9];
    typedef int vex_t[9];
    typedef struct {
        string nm;
        vex_t  ex;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    hazard_track_if #(.REG_W(5), .CNT_W(16)) hif ();

    hazard_track #(.REG_W(5), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (rst),
        .hif   (hif)
    );

    always #5 clk = ~clk;

    task automatic step(input string nm, input vin_t in, input vex_t ex);
        exp_t e;
        @(posedge clk);
        #1;
        hif.id_valid  = in[0][0];
        hif.id_rs     = 5'(in[1]);
        hif.id_rt     = 5'(in[2]);
        hif.id_rd     = 5'(in[3]);
        hif.id_regwr  = in[4][0];
        hif.id_memrd  = in[5][0];
        hif.flush     = in[6][0];
        hif.ext_stall = in[7][0];
        rst           = in[8][0];
        e.nm = nm;
        e.ex = ex;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input string fld, input int act, input int want);
        n_chk++;
        if (act == want) n_pass++;
        else $display("FAIL %s %s: got %0d expected %0d", nm, fld, act, want);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk(e.nm, "Drs",        int'(hif.Drs),        e.ex[0]);
            chk(e.nm, "Drt",        int'(hif.Drt),        e.ex[1]);
            chk(e.nm, "Xrd",        int'(hif.Xrd),        e.ex[2]);
            chk(e.nm, "Xrt",        int'(hif.Xrt),        e.ex[3]);
            chk(e.nm, "Mrd",        int'(hif.Mrd),        e.ex[4]);
            chk(e.nm, "Wrd",        int'(hif.Wrd),        e.ex[5]);
            chk(e.nm, "stall_d",    int'(hif.stall_d),    e.ex[6]);
            chk(e.nm, "stall_if",   int'(hif.stall_if),   e.ex[6]);
            chk(e.nm, "bubble_x",   int'(hif.bubble_x),   e.ex[7]);
            chk(e.nm, "bubble_cnt", int'(hif.bubble_cnt), e.ex[8]);
        end
    end

    initial begin
        hif.id_valid = 1'b0; hif.id_rs = '0; hif.id_rt = '0; hif.id_rd = '0;
        hif.id_regwr = 1'b0; hif.id_memrd = 1'b0; hif.flush = 1'b0; hif.ext_stall = 1'b0;

        step("reset",      '{0,0,0,0,0,0,0,0,1}, '{0,0,0,0,0,0,0,1,0});
        // load then dependent use
        step("lw_r8",      '{1,1,0,8,1,1,0,0,0}, '{1,0,0,0,0,0,0,1,0});
        step("use_r8",     '{1,8,1,9,1,0,0,0,0}, '{8,1,8,0,0,0,L,0,0});
        step("lu_bubble",  '{0,0,0,0,0,0,0,0,0}, '{0,0,(L!=0)?0:9,(L!=0)?0:1,8,0,0,L,L});
        step("lu_drain",   '{0,0,0,0,0,0,0,0,0}, '{0,0,0,0,(L!=0)?0:9,8,0,1,L});
        // ALU result feeding the next instruction: forwarded, never stalls
        step("add_r8",     '{1,1,2,8,1,0,0,0,0}, '{1,2,0,0,0,(L!=0)?0:9,0,1,L});
        step("sub_r8r8",   '{1,8,8,2,1,0,0,0,0}, '{8,8,8,2,0,0,0,0,L});
        step("alu_drain",  '{0,0,0,0,0,0,0,0,0}, '{0,0,2,8,8,0,0,0,L});
        // flush in the load-use cycle
        step("lw_r5",      '{1,3,0,5,1,1,0,0,0}, '{3,0,0,0,2,8,0,1,L});
        step("flush_lu",   '{1,5,0,4,1,0,1,0,0}, '{5,0,5,0,0,2,0,0,L});
        step("post_flush", '{0,0,0,0,0,0,0,0,0}, '{0,0,0,0,5,0,0,1,L});
        // external hold with X/M/W = 5/6/7
        step("wr_r7",      '{1,0,0,7,1,0,0,0,0}, '{0,0,0,0,0,5,0,1,L});
        step("wr_r6",      '{1,0,0,6,1,0,0,0,0}, '{0,0,7,0,0,0,0,0,L});
        step("wr_r5",      '{1,0,0,5,1,0,0,0,0}, '{0,0,6,0,7,0,0,0,L});
        for (int i = 0; i < 3; i++)
            step("ext_hold", '{0,0,0,0,0,0,0,1,0}, '{0,0,5,0,6,7,1,0,L});
        step("hold_rel",   '{0,0,0,0,0,0,0,0,0}, '{0,0,5,0,6,7,0,0,L});
        step("advance",    '{0,0,0,0,0,0,0,0,0}, '{0,0,0,0,5,6,0,1,L});
        // ext_stall overlapping a load-use: count deferred until release
        step("lw_r10",     '{1,0,0,10,1,1,0,0,0}, '{0,0,0,0,0,5,0,1,L});
        step("lu_ext0",    '{1,10,0,11,1,0,0,1,0}, '{10,0,10,0,0,0,1,0,L});
        step("lu_ext1",    '{1,10,0,11,1,0,0,1,0}, '{10,0,10,0,0,0,1,0,L});
        step("lu_ext_rel", '{1,10,0,11,1,0,0,0,0}, '{10,0,10,0,0,0,L,0,L});
        step("lu_counted", '{0,0,0,0,0,0,0,0,0}, '{0,0,(L!=0)?0:11,0,10,0,0,L,2*L});
        // writes to r0 are invisible, and a load to r0 never stalls
        step("lw_r0",      '{1,0,0,0,1,1,0,0,0}, '{0,0,0,0,(L!=0)?0:11,10,0,1,2*L});
        step("use_r0",     '{1,0,0,3,1,0,0,0,0}, '{0,0,0,0,0,(L!=0)?0:11,0,0,2*L});
        step("r0_drain",   '{0,0,0,0,0,0,0,0,0}, '{0,0,3,0,0,0,0,0,2*L});
        step("wr_r4",      '{1,0,0,4,1,0,0,0,0}, '{0,0,0,0,3,0,0,1,2*L});
        // asynchronous reset mid-stream: X=4, W=3 in flight, cleared at once
        step("mid_reset",  '{0,0,0,0,0,0,0,0,1}, '{0,0,0,0,0,0,0,1,0});
        step("after_rst",  '{0,0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,1,0});

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d expected entries left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
